// File: rtl/cnt_seq_checker.sv
// Receive-side monitor for free-running binary counters: checks +1 per valid sample, tracks lock.
// Optional macro CNT_CHK_HOLD_EN: a repeat of the previous accepted value is treated as a hold.
module cnt_seq_checker #(
    parameter int CNT_W     = 4,
    parameter int LOCK_CNT  = 3,
    parameter int MAX_MISS  = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CNT_W-1:0]     i_cnt,
    input  logic                 i_valid,
    output logic [1:0]           o_state,
    output logic                 o_locked,
    output logic                 o_err,
    output logic [ERR_CNT_W-1:0] o_err_cnt,
    output logic [CNT_W-1:0]     o_exp
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACQ    = 2'b01,
        LOCKED = 2'b10,
        LOST   = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0]     CNT_ONE  = 1;
    localparam logic [ERR_CNT_W-1:0] ERR_ONE  = 1;
    localparam logic [3:0]           LOCK_TH  = LOCK_CNT[3:0];
    localparam logic [3:0]           MISS_TH  = MAX_MISS[3:0];

    state_t     state;
    logic [3:0] run;
    logic [3:0] miss;
    logic [3:0] run_inc;
    logic [3:0] miss_inc;
    logic       match;
    logic       hold;

    assign match    = (i_cnt == o_exp);
    assign run_inc  = run + 4'd1;
    assign miss_inc = miss + 4'd1;
    assign o_state  = state;

`ifdef CNT_CHK_HOLD_EN
    logic [CNT_W-1:0] prev_cnt;
    assign prev_cnt = o_exp - CNT_ONE;
    // IDLE has no accepted history yet, so nothing can be a hold there.
    assign hold     = (i_cnt == prev_cnt) && (state != IDLE);
`else
    assign hold     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            run       <= '0;
            miss      <= '0;
            o_locked  <= 1'b0;
            o_err     <= 1'b0;
            o_err_cnt <= '0;
            o_exp     <= '0;
        end else begin
            o_err <= 1'b0;
            if (i_valid && !hold) begin
                // Every accepted sample resynchronises the expectation.
                o_exp <= i_cnt + CNT_ONE;
                case (state)
                    IDLE: begin
                        state <= ACQ;
                        run   <= '0;
                    end
                    ACQ: begin
                        if (match) begin
                            run <= run_inc;
                            if (run_inc >= LOCK_TH) begin
                                state    <= LOCKED;
                                o_locked <= 1'b1;
                                miss     <= '0;
                            end
                        end else begin
                            run <= '0;
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            miss <= '0;
                        end else begin
                            o_err <= 1'b1;
                            if (o_err_cnt != '1)
                                o_err_cnt <= o_err_cnt + ERR_ONE;
                            miss <= miss_inc;
                            if (miss_inc >= MISS_TH) begin
                                state    <= LOST;
                                o_locked <= 1'b0;
                            end
                        end
                    end
                    LOST: begin
                        state <= ACQ;
                        run   <= match ? 4'd1 : 4'd0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cnt_seq_checker.sv
// Directed bench for cnt_seq_checker with hand-computed expectations.
module tb_cnt_seq_checker;

    logic       clk;
    logic       rst_n;
    logic [3:0] i_cnt;
    logic       i_valid;
    logic [1:0] o_state;
    logic       o_locked;
    logic       o_err;
    logic [7:0] o_err_cnt;
    logic [3:0] o_exp;

    int errors = 0;
    int checks = 0;

    cnt_seq_checker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_cnt     (i_cnt),
        .i_valid   (i_valid),
        .o_state   (o_state),
        .o_locked  (o_locked),
        .o_err     (o_err),
        .o_err_cnt (o_err_cnt),
        .o_exp     (o_exp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive on negedge, sample 1ns after the following posedge.
    task automatic step(input logic [3:0] c, input logic v);
        @(negedge clk);
        i_cnt   = c;
        i_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_cnt   = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_all(input string tag, input int st, input int lk, input int er,
                           input int ec, input int ex);
        chk({tag, "_state"}, int'(o_state), st);
        chk({tag, "_locked"}, int'(o_locked), lk);
        chk({tag, "_err"}, int'(o_err), er);
        chk({tag, "_errcnt"}, int'(o_err_cnt), ec);
        chk({tag, "_exp"}, int'(o_exp), ex);
    endtask

    initial begin
        logic [3:0] e;
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_cnt   = 4'd0;
        #12;
        chk_all("reset", 0, 0, 0, 0, 0);
        do_reset();

        // Count 0..15,0,1: lock after the 4th sample, wrap is clean.
        step(4'd0, 1'b1); chk_all("s0", 1, 0, 0, 0, 1);
        step(4'd1, 1'b1); chk("s1_state", int'(o_state), 1);
        step(4'd2, 1'b1); chk("s2_state", int'(o_state), 1);
        step(4'd3, 1'b1); chk_all("s3", 2, 1, 0, 0, 4);
        for (int i = 4; i < 18; i++) begin
            step(4'(i), 1'b1);
            chk("wrap_err", int'(o_err), 0);
            chk("wrap_state", int'(o_state), 2);
        end
        chk_all("wrap_end", 2, 1, 0, 0, 2);

        // Single glitch 9 after 6, then 10.
        for (int i = 2; i <= 6; i++) step(4'(i), 1'b1);
        step(4'd9, 1'b1);  chk_all("glitch", 2, 1, 1, 1, 10);
        step(4'd10, 1'b1); chk_all("glitch_after", 2, 1, 0, 1, 11);

        // Two consecutive mismatches drop lock.
        for (int i = 11; i <= 19; i++) step(4'(i), 1'b1);
        chk("pre_lost_exp", int'(o_exp), 4);
        step(4'd9, 1'b1); chk_all("miss1", 2, 1, 1, 2, 10);
        step(4'd2, 1'b1); chk_all("miss2", 3, 0, 1, 3, 3);
        step(4'd8, 1'b1); chk_all("lost_acq", 1, 0, 0, 3, 9);
        step(4'd9, 1'b1);  chk("relock1", int'(o_state), 1);
        step(4'd10, 1'b1); chk("relock2", int'(o_state), 1);
        step(4'd11, 1'b1); chk_all("relock3", 2, 1, 0, 3, 12);

        // Upstream reset: 7 then 0 held for one extra cycle.
        for (int i = 12; i <= 23; i++) step(4'(i), 1'b1);
        chk("pre_hold_exp", int'(o_exp), 8);
        step(4'd0, 1'b1); chk_all("ureset0", 2, 1, 1, 4, 1);
        step(4'd0, 1'b1);
`ifdef CNT_CHK_HOLD_EN
        chk_all("ureset_hold", 2, 1, 0, 4, 1);
        step(4'd1, 1'b1); chk_all("ureset_resume", 2, 1, 0, 4, 2);
`else
        chk_all("ureset_rep", 3, 0, 1, 5, 1);
        step(4'd1, 1'b1); chk_all("ureset_acq_run1", 1, 0, 0, 5, 2);
        step(4'd2, 1'b1); chk("run1_acq", int'(o_state), 1);
        step(4'd3, 1'b1); chk("run1_lock", int'(o_state), 2);
`endif

        // Valid gating: garbage on invalid cycles has no effect.
        do_reset();
        chk_all("rst2", 0, 0, 0, 0, 0);
        step(4'd5, 1'b1);  chk_all("v5", 1, 0, 0, 0, 6);
        step(4'd13, 1'b0); chk_all("inv13", 1, 0, 0, 0, 6);
        step(4'd6, 1'b1);  chk("v6_exp", int'(o_exp), 7);
        step(4'd0, 1'b0);  chk_all("inv0", 1, 0, 0, 0, 7);
        step(4'd7, 1'b1);  chk("v7_state", int'(o_state), 1);
        step(4'd3, 1'b0);  chk_all("inv3", 1, 0, 0, 0, 8);
        step(4'd8, 1'b1);  chk_all("v8_lock", 2, 1, 0, 0, 9);

        // 260 LOCKED mismatches, each followed by a match to keep lock.
        e = 4'd9;
        for (int i = 1; i <= 260; i++) begin
            step(e, 1'b1);
            e = e + 4'd1;
            step(e + 4'd5, 1'b1);
            e = e + 4'd6;
            chk("sat_err", int'(o_err), 1);
            chk("sat_cnt", int'(o_err_cnt), (i > 255) ? 255 : i);
        end
        chk_all("sat_end", 2, 1, 1, 255, int'(e));

        // Asynchronous reset mid-cycle, no clock edge needed.
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0);
        #20;
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
